// File: rtl/autoscale_pkg.sv
// Shared helpers for the autoscale normaliser and its inverse: shift-width derivation,
// shift clamping and the round-half-up constant.
package autoscale_pkg;

  localparam int DEF_DIN_WIDTH = 32;
  localparam int DEF_MAX_SHIFT = 10;

  function automatic int shift_width(input int din_width);
    return $clog2(din_width);
  endfunction

  function automatic int clamp_shift(input int shift, input int max_shift);
    return (shift > max_shift) ? max_shift : shift;
  endfunction

  // Scaled shift, limited so an arithmetic right shift never clears the sign bit position.
  function automatic int eff_shift(input int shift, input int scale, input int din_width);
    int s;
    s = shift * scale;
    return (s > din_width - 1) ? din_width - 1 : s;
  endfunction

  function automatic longint round_const(input int e);
    return (e > 0) ? (longint'(1) << (e - 1)) : 64'sd0;
  endfunction

endpackage

// File: rtl/autoscale_restore_shift_fifo.sv
// Plain synchronous FIFO with registered pointers; the caller guarantees no write
// when full and no read when empty.
module shift_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/autoscale_restore.sv
// Undoes the normaliser's left shift on downstream results: pops the matching shift
// from a FIFO and applies a rounded (or floored) arithmetic right shift over 2 stages.
module autoscale_restore
  import autoscale_pkg::*;
#(
  parameter int DIN_WIDTH   = DEF_DIN_WIDTH,
  parameter int MAX_SHIFT   = DEF_MAX_SHIFT,
  parameter int SHIFT_WIDTH = shift_width(DIN_WIDTH),
  parameter int SHIFT_SCALE = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int ROUND       = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SHIFT_WIDTH-1:0]        shift_in,
  input  logic                          shift_valid,
  input  logic [DIN_WIDTH-1:0]          din,
  input  logic                          din_valid,
  output logic [DIN_WIDTH-1:0]          dout,
  output logic                          dout_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int EW  = $clog2(DIN_WIDTH);
  localparam int LAT = 2;

  logic                   empty, full, push, pop;
  logic [SHIFT_WIDTH-1:0] clamped, head;
  logic [EW-1:0]          e, s1_e;
  logic [DIN_WIDTH:0]     rc;
  logic signed [DIN_WIDTH:0] sum, s1_sum;
  logic [LAT-1:0]         vld_pipe;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = din_valid && !empty;
  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
  assign push  = shift_valid && (!full || pop);

  assign clamped = SHIFT_WIDTH'(clamp_shift(int'(shift_in), MAX_SHIFT));

  shift_fifo #(
    .WIDTH (SHIFT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (push),
    .wdata (clamped),
    .rd_en (pop),
    .rdata (head),
    .count (count)
  );

  // Underflowing results pass through unshifted.
  assign e   = pop ? EW'(eff_shift(int'(head), SHIFT_SCALE, DIN_WIDTH)) : '0;
  assign rc  = (ROUND != 0) ? (DIN_WIDTH+1)'(round_const(int'(e))) : '0;
  assign sum = $signed({din[DIN_WIDTH-1], din}) + $signed(rc);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      s1_sum     <= '0;
      s1_e       <= '0;
      dout       <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-2:0], din_valid};
      if (din_valid) begin
        s1_sum <= sum;
        s1_e   <= e;
      end
      if (vld_pipe[0]) dout <= DIN_WIDTH'(s1_sum >>> s1_e);
      if (shift_valid && full && !pop) overflow <= 1'b1;
      if (din_valid && empty) underflow <= 1'b1;
    end
  end

  assign dout_valid = vld_pipe[LAT-1];

endmodule

// File: tb/tb_autoscale_restore.sv
// Drives three configurations (round, truncate, squared scale) with one stimulus
// stream and checks every cycle against a queue-based reference.
module tb_autoscale_restore;

  localparam int NC = 3;

  logic        clk = 1'b0;
  logic        rst, shift_valid, din_valid;
  logic [4:0]  shift_in;
  logic [31:0] din;

  logic [31:0] dout     [NC];
  logic        dout_vld [NC];
  logic [4:0]  cnt      [NC];
  logic        ovf      [NC];
  logic        udf      [NC];

  always #5 clk = ~clk;

  autoscale_restore dut_r1 (
    .clk(clk), .rst(rst), .shift_in(shift_in), .shift_valid(shift_valid),
    .din(din), .din_valid(din_valid), .dout(dout[0]), .dout_valid(dout_vld[0]),
    .count(cnt[0]), .overflow(ovf[0]), .underflow(udf[0]));

  autoscale_restore #(.ROUND(0)) dut_r0 (
    .clk(clk), .rst(rst), .shift_in(shift_in), .shift_valid(shift_valid),
    .din(din), .din_valid(din_valid), .dout(dout[1]), .dout_valid(dout_vld[1]),
    .count(cnt[1]), .overflow(ovf[1]), .underflow(udf[1]));

  autoscale_restore #(.SHIFT_SCALE(2)) dut_s2 (
    .clk(clk), .rst(rst), .shift_in(shift_in), .shift_valid(shift_valid),
    .din(din), .din_valid(din_valid), .dout(dout[2]), .dout_valid(dout_vld[2]),
    .count(cnt[2]), .overflow(ovf[2]), .underflow(udf[2]));

  int          scale_c [NC] = '{1, 1, 2};
  bit          rnd_c   [NC] = '{1, 0, 1};

  int          tests = 0;
  int          fails = 0;
  int          q[$];
  bit          m_ovf, m_udf;
  bit          st1_v [NC], st2_v [NC];
  logic [31:0] st1_d [NC], st2_d [NC];
  logic [31:0] last_out [NC];

  // Rescale by plain integer arithmetic: add half an LSB of the target scale, then floor-divide.
  function automatic logic [31:0] ref_rescale(input logic [31:0] d, input int s, input bit rnd);
    longint v;
    int e;
    e = (s > 31) ? 31 : s;
    v = longint'($signed(d));
    if (rnd && e > 0) v = v + (longint'(1) << (e - 1));
    return 32'(v >>> e);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit sv, input int si, input bit dv, input logic [31:0] d);
    int  sz, s;
    bit  pop;
    rst = r; shift_valid = sv; shift_in = si[4:0]; din_valid = dv; din = d;
    @(posedge clk); #1;
    for (int c = 0; c < NC; c++) begin
      st2_v[c] = st1_v[c];
      st2_d[c] = st1_d[c];
    end
    if (r) begin
      q.delete();
      m_ovf = 0; m_udf = 0;
      for (int c = 0; c < NC; c++) begin st1_v[c] = 0; st2_v[c] = 0; end
    end else begin
      sz  = q.size();
      pop = dv && sz > 0;
      s   = 0;
      if (dv && sz == 0) m_udf = 1;
      if (pop) s = q.pop_front();
      if (sv) begin
        if (sz < 16 || pop) q.push_back(si > 10 ? 10 : si);
        else m_ovf = 1;
      end
      for (int c = 0; c < NC; c++) begin
        st1_v[c] = dv;
        st1_d[c] = ref_rescale(d, s * scale_c[c], rnd_c[c]);
      end
    end
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("c%0d_dout_valid", c), 32'(dout_vld[c]), 32'(st2_v[c]));
      if (st2_v[c]) begin
        chk($sformatf("c%0d_dout", c), dout[c], st2_d[c]);
        last_out[c] = dout[c];
      end
      if (r) chk($sformatf("c%0d_dout_rst", c), dout[c], 32'h0);
      chk($sformatf("c%0d_count", c), 32'(cnt[c]), 32'(q.size()));
      chk($sformatf("c%0d_overflow", c), 32'(ovf[c]), 32'(m_ovf));
      chk($sformatf("c%0d_underflow", c), 32'(udf[c]), 32'(m_udf));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    // reset
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    chk("rst_count", 32'(cnt[0]), 32'h0);

    // basic shift-by-3
    step(0, 1, 3, 0, 32'h0);
    chk("t1_count_after_push", 32'(cnt[0]), 32'd1);
    step(0, 0, 0, 1, 32'h0000_0100);
    chk("t1_count_after_pop", 32'(cnt[0]), 32'd0);
    idle(1);
    chk("t1_dout_valid", 32'(dout_vld[0]), 32'd1);
    chk("t1_dout", dout[0], 32'h20);

    // rounding vs truncation around the half point
    step(0, 1, 2, 0, 32'h0);
    step(0, 0, 0, 1, 32'd6);
    idle(1);
    chk("t2_r1_pos", last_out[0], 32'd2);
    chk("t2_r0_pos", last_out[1], 32'd1);
    step(0, 1, 2, 0, 32'h0);
    step(0, 0, 0, 1, -32'sd6);
    idle(1);
    chk("t2_r1_neg", last_out[0], 32'hFFFF_FFFF);
    chk("t2_r0_neg", last_out[1], 32'hFFFF_FFFE);

    // clamp to MAX_SHIFT, and squared scale
    step(0, 1, 15, 0, 32'h0);
    step(0, 0, 0, 1, 32'h400);
    idle(1);
    chk("t3_clamp", last_out[0], 32'd1);
    step(0, 1, 3, 0, 32'h0);
    step(0, 0, 0, 1, 32'h40);
    idle(1);
    chk("t3_scale2", last_out[2], 32'd1);

    // fill, push+pop on full, overflow, drain in order
    step(1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 16; i++) step(0, 1, i % 11, 0, 32'h0);
    chk("t4_full_count", 32'(cnt[0]), 32'd16);
    step(0, 1, 7, 1, 32'h0010_0000);
    chk("t4_pushpop_count", 32'(cnt[0]), 32'd16);
    chk("t4_pushpop_ovf", 32'(ovf[0]), 32'd0);
    step(0, 1, 9, 0, 32'h0);
    chk("t4_ovf", 32'(ovf[0]), 32'd1);
    chk("t4_ovf_count", 32'(cnt[0]), 32'd16);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 32'h0010_0000 + 32'(i));
    idle(2);

    // underflow passes data through unshifted
    step(1, 0, 0, 0, 32'h0);
    step(0, 0, 0, 1, 32'h1234);
    chk("t5_udf", 32'(udf[0]), 32'd1);
    idle(1);
    chk("t5_dout", dout[0], 32'h1234);

    // reset during S1 kills in-flight results
    step(1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 4, 0, 32'h0);
    step(0, 0, 0, 1, 32'h100);
    step(0, 0, 0, 1, 32'h200);
    step(1, 0, 0, 0, 32'h0);
    chk("t6_dout_valid", 32'(dout_vld[0]), 32'd0);
    chk("t6_count", 32'(cnt[0]), 32'd0);
    idle(3);

    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($signed($urandom_range(0, 4000)) - 2000);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 55, $urandom_range(0, 31),
           $urandom_range(0, 99) < 50, d);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
